// File: rtl/decode_exec_stage.sv
// Single-issue MIPS decode/execute stage: ALU, branches and jumps resolve one cycle after
// acceptance, and LW/SW hold a memory request until acknowledged or timed out.
module decode_exec_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int LINK_REG    = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [ADDR_W-1:0] pc,
  output logic [4:0]        reg1_addr,
  output logic [4:0]        reg2_addr,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              jmp_valid,
  output logic [ADDR_W-1:0] jmp_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              illegal,
  output logic              mem_err
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [0:0] {IDLE, MEM_WAIT} state_t;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return DATA_W'($signed(v));
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  state_t state, state_nxt;
  logic [CNT_W-1:0] wait_cnt_p1;
  logic [4:0]       ld_dest_p1;
  logic             fire, timeout_hit;

  logic [5:0]               op_p0, funct_p0;
  logic [4:0]               rd_p0, rt_addr_p0;
  logic signed [DATA_W-1:0] rs_p0, rt_p0, simm_p0;
  logic [DATA_W-1:0]        zimm_p0, link_p0;
  logic [SH_W-1:0]          sh_amt_p0;
  logic [ADDR_W-1:0]        pc4_p0, br_tgt_p0, j_tgt_p0, ea_p0;
  logic signed [ADDR_W-1:0] boff_p0;

  logic              wr_en_p0, jmp_p0, mem_op_p0, store_p0, ill_p0;
  logic [4:0]        wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic [ADDR_W-1:0] jmp_tgt_p0;

  assign in_ready    = (state == IDLE);
  assign fire        = in_valid && in_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_p1 == CNT_W'(MEM_TIMEOUT - 1));

  assign reg1_addr  = inst[25:21];
  assign reg2_addr  = inst[20:16];
  assign op_p0      = inst[31:26];
  assign funct_p0   = inst[5:0];
  assign rd_p0      = inst[15:11];
  assign rt_addr_p0 = inst[20:16];
  assign rs_p0      = reg1_data;
  assign rt_p0      = reg2_data;
  assign simm_p0    = sext16(inst[15:0]);
  assign zimm_p0    = zext16(inst[15:0]);
  // Variable shifts have funct bit 2 set; fixed shifts take shamt.
  assign sh_amt_p0  = funct_p0[2] ? reg1_data[SH_W-1:0] : SH_W'(inst[10:6]);
  assign pc4_p0     = pc + ADDR_W'(4);
  assign boff_p0    = ADDR_W'($signed(inst[15:0]));
  assign br_tgt_p0  = pc4_p0 + (boff_p0 <<< 2);
  assign j_tgt_p0   = {pc4_p0[ADDR_W-1:28], inst[25:0], 2'b00};
  assign link_p0    = DATA_W'(pc + ADDR_W'(8));
  assign ea_p0      = to_addr(rs_p0 + simm_p0);

  always_comb begin
    wr_en_p0   = 1'b0;
    wr_addr_p0 = rd_p0;
    wr_data_p0 = '0;
    jmp_p0     = 1'b0;
    jmp_tgt_p0 = br_tgt_p0;
    mem_op_p0  = 1'b0;
    store_p0   = 1'b0;
    ill_p0     = 1'b0;
    case (op_p0)
      6'h00: begin
        wr_en_p0 = 1'b1;
        case (funct_p0)
          6'h20, 6'h21: wr_data_p0 = rs_p0 + rt_p0;
          6'h22, 6'h23: wr_data_p0 = rs_p0 - rt_p0;
          6'h24:        wr_data_p0 = rs_p0 & rt_p0;
          6'h25:        wr_data_p0 = rs_p0 | rt_p0;
          6'h26:        wr_data_p0 = rs_p0 ^ rt_p0;
          6'h27:        wr_data_p0 = ~(rs_p0 | rt_p0);
          6'h2A:        wr_data_p0 = DATA_W'(rs_p0 < rt_p0);
          6'h2B:        wr_data_p0 = DATA_W'($unsigned(rs_p0) < $unsigned(rt_p0));
          6'h00, 6'h04: wr_data_p0 = rt_p0 << sh_amt_p0;
          6'h02, 6'h06: wr_data_p0 = $unsigned(rt_p0) >> sh_amt_p0;
          6'h03, 6'h07: wr_data_p0 = rt_p0 >>> sh_amt_p0;
          6'h08: begin
            wr_en_p0   = 1'b0;
            jmp_p0     = 1'b1;
            jmp_tgt_p0 = to_addr(rs_p0);
          end
          default: begin
            wr_en_p0 = 1'b0;
            ill_p0   = 1'b1;
          end
        endcase
      end
      6'h02: begin
        jmp_p0     = 1'b1;
        jmp_tgt_p0 = j_tgt_p0;
      end
      6'h03: begin
        jmp_p0     = 1'b1;
        jmp_tgt_p0 = j_tgt_p0;
        wr_en_p0   = 1'b1;
        wr_addr_p0 = 5'(LINK_REG);
        wr_data_p0 = link_p0;
      end
      6'h04: jmp_p0 = (rs_p0 == rt_p0);
      6'h05: jmp_p0 = (rs_p0 != rt_p0);
      6'h06: jmp_p0 = rs_p0[DATA_W-1] || (rs_p0 == '0);
      6'h07: jmp_p0 = !rs_p0[DATA_W-1] && (rs_p0 != '0);
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        wr_en_p0   = 1'b1;
        wr_addr_p0 = rt_addr_p0;
        case (op_p0[2:0])
          3'd0, 3'd1: wr_data_p0 = rs_p0 + simm_p0;
          3'd2:       wr_data_p0 = DATA_W'(rs_p0 < simm_p0);
          3'd3:       wr_data_p0 = DATA_W'($unsigned(rs_p0) < $unsigned(simm_p0));
          3'd4:       wr_data_p0 = rs_p0 & zimm_p0;
          3'd5:       wr_data_p0 = rs_p0 | zimm_p0;
          3'd6:       wr_data_p0 = rs_p0 ^ zimm_p0;
          default:    wr_data_p0 = simm_p0 << 16;
        endcase
      end
      6'h23: mem_op_p0 = 1'b1;
      6'h2B: begin
        mem_op_p0 = 1'b1;
        store_p0  = 1'b1;
      end
      default: ill_p0 = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (fire && mem_op_p0) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ack || timeout_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- p1: registered results and memory handshake ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      jmp_valid   <= 1'b0;
      jmp_addr    <= '0;
      illegal     <= 1'b0;
      mem_err     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wait_cnt_p1 <= '0;
      ld_dest_p1  <= '0;
    end else begin
      wb_valid  <= 1'b0;
      jmp_valid <= 1'b0;
      illegal   <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: if (fire) begin
          wb_valid  <= wr_en_p0 && (wr_addr_p0 != 5'd0);
          wb_addr   <= wr_addr_p0;
          wb_data   <= wr_data_p0;
          jmp_valid <= jmp_p0;
          jmp_addr  <= jmp_tgt_p0;
          illegal   <= ill_p0;
          if (mem_op_p0) begin
            mem_req     <= 1'b1;
            mem_we      <= store_p0;
            mem_addr    <= ea_p0;
            mem_wdata   <= reg2_data;
            ld_dest_p1  <= rt_addr_p0;
            wait_cnt_p1 <= '0;
          end
        end
        MEM_WAIT: begin
          // Ack beats a simultaneous timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              wb_valid <= (ld_dest_p1 != 5'd0);
              wb_addr  <= ld_dest_p1;
              wb_data  <= mem_rdata;
            end
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            wait_cnt_p1 <= wait_cnt_p1 + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
